// File: rtl/nrisc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : nrisc_pkg
// Description : Definitions shared by the nRisc core, its memories and the
//               run controller. Holds the run-state encoding, the default
//               halt opcode and the default address and instruction widths.
// Revision    : 1.0 - initial release
// ============================================================================
package nrisc_pkg;

    // Widths used by the core and by the instruction memory
    localparam int unsigned c_ADDR_W      = 8;
    localparam int unsigned c_INSTR_W     = 8;

    // Instruction value that ends a program
    localparam int unsigned c_HALT_OPCODE = 0;

    // Run-control states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BOOT    = 3'd1,
        RUN     = 3'd2,
        HALT    = 3'd3,
        TIMEOUT = 3'd4
    } run_state_t;

endpackage
`default_nettype wire

// File: rtl/run_controller_if.sv
`default_nettype none
// ============================================================================
// Interface   : run_controller_if
// Description : Host/core side signal bundle of the run controller.
//               master : host side. Drives Start, PC, Instrucao and TraceRead.
//               slave  : run controller. Drives the core controls, the status
//                        outputs and the trace FIFO head.
// Revision    : 1.0 - initial release
// ============================================================================
interface run_controller_if #(
    parameter int unsigned ADDR_W  = nrisc_pkg::c_ADDR_W,
    parameter int unsigned INSTR_W = nrisc_pkg::c_INSTR_W,
    parameter int unsigned CYCLE_W = 16
);
    logic                 Start;
    logic [ADDR_W-1:0]    PC;
    logic [INSTR_W-1:0]   Instrucao;
    logic                 CoreReset;
    logic                 CoreRun;
    logic                 Halted;
    logic                 TimedOut;
    logic [CYCLE_W-1:0]   CycleCount;
    logic                 TraceRead;
    logic                 TraceValid;
    logic [ADDR_W-1:0]    TracePC;
    logic [INSTR_W-1:0]   TraceInstr;
    logic                 TraceOverflow;

    modport master (
        output Start, PC, Instrucao, TraceRead,
        input  CoreReset, CoreRun, Halted, TimedOut, CycleCount,
               TraceValid, TracePC, TraceInstr, TraceOverflow
    );

    modport slave (
        input  Start, PC, Instrucao, TraceRead,
        output CoreReset, CoreRun, Halted, TimedOut, CycleCount,
               TraceValid, TracePC, TraceInstr, TraceOverflow
    );
endinterface
`default_nettype wire

// File: rtl/run_controller_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : Show-ahead FIFO holding the retired (PC, instruction) trace.
//               Read and write pointers carry one extra wrap bit, so full and
//               empty are told apart without an occupancy counter.
// Ports       : Clock, Reset (sync, active low), clear (sync empty),
//               push/din (write), pop/dout (read, dout = head entry),
//               full, empty
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned c_PTR_W = $clog2(DEPTH);

    logic [c_PTR_W:0]  r_wr_ptr;
    logic [c_PTR_W:0]  r_rd_ptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              w_do_pop;
    logic              w_do_push;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                   (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

    // A pop on an empty FIFO is ignored. A push into a full FIFO only lands
    // when a pop frees a slot on the same edge.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign dout = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    always_ff @(posedge Clock) begin
        if (!Reset || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only visible once a push has written it
    always_ff @(posedge Clock) begin
        if (w_do_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= din;
    end
endmodule
`default_nettype wire

// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
// Module      : run_controller
// Description : Run-control and trace unit for the nRisc core. Holds the core
//               in reset while booting, then gates it with a clock-enable.
//               Stops on the halt opcode or when the cycle budget runs out.
//               Every retired (PC, instruction) pair is recorded in a trace
//               FIFO that the host can drain.
// Ports       : Clock   - system clock, rising edge
//               Reset   - synchronous active-low reset
//               bus     - run_controller_if.slave: Start, PC, Instrucao and
//                         TraceRead in; CoreReset, CoreRun, Halted, TimedOut,
//                         CycleCount, TraceValid/TracePC/TraceInstr and
//                         TraceOverflow out
// Revision    : 1.0 - initial release
// ============================================================================
module run_controller
    import nrisc_pkg::*;
#(
    parameter int unsigned ADDR_W      = c_ADDR_W,
    parameter int unsigned INSTR_W     = c_INSTR_W,
    parameter int unsigned HALT_OPCODE = c_HALT_OPCODE,
    parameter int unsigned CYCLE_W     = 16,
    parameter int unsigned MAX_CYCLES  = 1000,
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    run_controller_if.slave bus
);
    localparam logic [INSTR_W-1:0]  c_HALT      = INSTR_W'(HALT_OPCODE);
    localparam int unsigned         c_BOOT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [c_BOOT_W-1:0] c_BOOT_LAST = c_BOOT_W'(BOOT_CYCLES - 1);
    localparam int unsigned         c_FIFO_W    = ADDR_W + INSTR_W;

    run_state_t            r_state;
    logic [c_BOOT_W-1:0]   r_boot_cnt;
    logic [CYCLE_W-1:0]    r_cycle_count;
    logic                  r_core_reset;
    logic                  r_core_run;
    logic                  r_halted;
    logic                  r_timed_out;
    logic                  r_overflow;

    logic                  w_start_ok;
    logic                  w_is_halt;
    logic                  w_push;
    logic                  w_drop;
    logic [CYCLE_W:0]      w_count_inc;
    logic                  w_budget_hit;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [c_FIFO_W-1:0]   w_fifo_dout;

    // Start is honoured only while the core is parked
    assign w_start_ok = bus.Start &&
                        ((r_state == IDLE) || (r_state == HALT) || (r_state == TIMEOUT));
    assign w_is_halt  = (bus.Instrucao == c_HALT);
    assign w_push     = (r_state == RUN) && !w_is_halt;

    // Full with no pop on the same edge means the new entry is lost
    assign w_drop     = w_push && w_fifo_full && !bus.TraceRead;

    // The budget test uses the unsaturated successor, so a budget equal to
    // 2^CYCLE_W is still reached once
    assign w_count_inc  = {1'b0, r_cycle_count} + 1'b1;
    assign w_budget_hit = (MAX_CYCLES != 0) && (64'(w_count_inc) == 64'(MAX_CYCLES));

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state       <= IDLE;
            r_boot_cnt    <= '0;
            r_cycle_count <= '0;
            r_core_reset  <= 1'b1;
            r_core_run    <= 1'b0;
            r_halted      <= 1'b0;
            r_timed_out   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, HALT, TIMEOUT: begin
                    if (bus.Start) begin
                        r_state       <= BOOT;
                        r_boot_cnt    <= '0;
                        r_cycle_count <= '0;
                        r_core_reset  <= 1'b1;
                        r_core_run    <= 1'b0;
                        r_halted      <= 1'b0;
                        r_timed_out   <= 1'b0;
                    end
                end
                BOOT: begin
                    if (r_boot_cnt == c_BOOT_LAST) begin
                        r_state      <= RUN;
                        r_core_reset <= 1'b0;
                        r_core_run   <= 1'b1;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + c_BOOT_W'(1);
                    end
                end
                RUN: begin
                    // Halt is tested first so it wins over an expiring budget
                    if (w_is_halt) begin
                        r_state    <= HALT;
                        r_halted   <= 1'b1;
                        r_core_run <= 1'b0;
                    end else begin
                        if (r_cycle_count != {CYCLE_W{1'b1}})
                            r_cycle_count <= r_cycle_count + 1'b1;
                        if (w_budget_hit) begin
                            r_state     <= TIMEOUT;
                            r_timed_out <= 1'b1;
                            r_core_run  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_core_reset <= 1'b1;
                    r_core_run   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky drop flag, cleared together with the FIFO
    always_ff @(posedge Clock) begin
        if (!Reset || w_start_ok)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
    end

    trace_fifo #(
        .WIDTH (c_FIFO_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .clear (w_start_ok),
        .push  (w_push),
        .pop   (bus.TraceRead),
        .din   ({bus.PC, bus.Instrucao}),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign bus.CoreReset     = r_core_reset;
    assign bus.CoreRun       = r_core_run;
    assign bus.Halted        = r_halted;
    assign bus.TimedOut      = r_timed_out;
    assign bus.CycleCount    = r_cycle_count;
    assign bus.TraceOverflow = r_overflow;
    assign bus.TraceValid    = !w_fifo_empty;
    assign {bus.TracePC, bus.TraceInstr} = w_fifo_dout;
endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_controller
// Description : Self-checking bench for run_controller. The bench plays the
//               host and the core. A queue model of the trace and the run
//               outcome sets the expected values, and a monitor compares them
//               against what the DUT presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_controller;
    localparam int ADDR_W      = 8;
    localparam int INSTR_W     = 8;
    localparam int CYCLE_W     = 16;
    localparam int MAX_CYCLES  = 12;
    localparam int BOOT_CYCLES = 2;
    localparam int DEPTH       = 8;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    run_controller_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CYCLE_W(CYCLE_W)) bus ();

    run_controller #(
        .ADDR_W      (ADDR_W),
        .INSTR_W     (INSTR_W),
        .HALT_OPCODE (0),
        .CYCLE_W     (CYCLE_W),
        .MAX_CYCLES  (MAX_CYCLES),
        .BOOT_CYCLES (BOOT_CYCLES),
        .TRACE_DEPTH (DEPTH)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    typedef struct {
        bit halted;
        bit timedout;
        int count;
        bit ovf;
    } status_t;

    entry_t     mq[$];      // model of the trace FIFO contents
    entry_t     exp_q[$];   // expected entries for issued reads
    status_t    end_q[$];   // expected outcome of the current run
    status_t    last_st;
    bit         movf;
    logic [7:0] prog[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // ---------------- monitor ----------------
    entry_t  mon_e;
    status_t mon_s;
    bit      prev_done = 1'b0;
    bit      cur_done;

    always @(negedge Clock) begin
        if (Reset) begin
            if (bus.TraceRead && bus.TraceValid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL trace_unexpected: got entry pc=%0h instr=%0h, required no entry",
                             bus.TracePC, bus.TraceInstr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("trace_pc", bus.TracePC, mon_e.pc);
                    chk("trace_instr", bus.TraceInstr, mon_e.instr);
                end
            end
            cur_done = bus.Halted || bus.TimedOut;
            if (cur_done && !prev_done) begin
                if (end_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL run_end_unexpected: got halted=%0b timedout=%0b, required still running",
                             bus.Halted, bus.TimedOut);
                end else begin
                    mon_s = end_q.pop_front();
                    chk("end_halted", bus.Halted, mon_s.halted);
                    chk("end_timedout", bus.TimedOut, mon_s.timedout);
                    chk("end_cyclecount", bus.CycleCount, mon_s.count);
                    chk("end_overflow", bus.TraceOverflow, mon_s.ovf);
                    chk("end_corerun", bus.CoreRun, 0);
                end
            end
            prev_done = cur_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic make_prog(input int n, input logic [7:0] val);
        prog.delete();
        for (int i = 0; i < n; i++)
            prog.push_back((val != 8'h00) ? val : 8'($urandom_range(1, 255)));
        prog.push_back(8'h00);
    endtask

    // read_mode: 0 none, 1 random, 2 from run cycle DEPTH onward
    task automatic run_prog(input int read_mode, input int start_mid_at,
                            input int abort_at, input bit noisy_boot);
        int     cnt;
        bit     rd;
        bit     done;
        entry_t e;
        bus.Start     = 1'b1;
        bus.TraceRead = 1'b0;
        mq.delete();
        movf = 1'b0;
        tick();
        chk("boot_corereset", bus.CoreReset, 1);
        chk("boot_corerun", bus.CoreRun, 0);
        for (int b = 1; b <= BOOT_CYCLES; b++) begin
            bus.Start     = noisy_boot ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.TraceRead = 1'($urandom_range(0, 1));
            bus.PC        = 8'($urandom_range(0, 255));
            bus.Instrucao = 8'($urandom_range(0, 255));
            tick();
            if (b < BOOT_CYCLES) begin
                chk("boot_hold_corereset", bus.CoreReset, 1);
                chk("boot_hold_corerun", bus.CoreRun, 0);
            end
        end
        chk("run_corerun", bus.CoreRun, 1);
        chk("run_corereset", bus.CoreReset, 0);
        cnt  = 0;
        done = 1'b0;
        for (int k = 0; !done; k++) begin
            if (k == abort_at) begin
                Reset         = 1'b0;
                bus.Start     = 1'b0;
                bus.TraceRead = 1'b0;
                tick();
                Reset = 1'b1;
                mq.delete();
                movf = 1'b0;
                chk("abort_corereset", bus.CoreReset, 1);
                chk("abort_corerun", bus.CoreRun, 0);
                chk("abort_cyclecount", bus.CycleCount, 0);
                chk("abort_tracevalid", bus.TraceValid, 0);
                chk("abort_overflow", bus.TraceOverflow, 0);
                return;
            end
            bus.Start = (k == start_mid_at);
            case (read_mode)
                0:       rd = 1'b0;
                1:       rd = 1'($urandom_range(0, 1));
                default: rd = (k >= DEPTH);
            endcase
            bus.TraceRead = rd;
            bus.PC        = ADDR_W'(k);
            bus.Instrucao = prog[k];
            if (rd && mq.size() > 0) exp_q.push_back(mq.pop_front());
            if (prog[k] == 8'h00) begin
                last_st = '{halted: 1'b1, timedout: 1'b0, count: cnt, ovf: movf};
                end_q.push_back(last_st);
                done = 1'b1;
            end else begin
                e.pc    = ADDR_W'(k);
                e.instr = prog[k];
                if (mq.size() < DEPTH) mq.push_back(e);
                else                   movf = 1'b1;
                cnt++;
                if (cnt == MAX_CYCLES) begin
                    last_st = '{halted: 1'b0, timedout: 1'b1, count: cnt, ovf: movf};
                    end_q.push_back(last_st);
                    done = 1'b1;
                end
            end
            tick();
        end
        bus.Start     = 1'b0;
        bus.TraceRead = 1'b0;
        drain();
    endtask

    task automatic drain();
        bit rd;
        for (int i = 0; i < 200 && mq.size() > 0; i++) begin
            rd = ($urandom_range(0, 3) != 0);
            bus.TraceRead = rd;
            if (rd) exp_q.push_back(mq.pop_front());
            tick();
        end
        // Reads on an empty FIFO must change nothing
        bus.TraceRead = 1'b1;
        tick();
        tick();
        bus.TraceRead = 1'b0;
        chk("drained_tracevalid", bus.TraceValid, 0);
        chk("drained_pending_reads", exp_q.size(), 0);
        chk("drained_pending_end", end_q.size(), 0);
        chk("hold_halted", bus.Halted, last_st.halted);
        chk("hold_timedout", bus.TimedOut, last_st.timedout);
        chk("hold_cyclecount", bus.CycleCount, last_st.count);
        chk("hold_overflow", bus.TraceOverflow, last_st.ovf);
        chk("hold_corerun", bus.CoreRun, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.Start     = 1'b0;
        bus.PC        = '0;
        bus.Instrucao = '0;
        bus.TraceRead = 1'b0;
        Reset         = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        chk("reset_corereset", bus.CoreReset, 1);
        chk("reset_corerun", bus.CoreRun, 0);
        chk("reset_halted", bus.Halted, 0);
        chk("reset_timedout", bus.TimedOut, 0);
        chk("reset_cyclecount", bus.CycleCount, 0);
        chk("reset_tracevalid", bus.TraceValid, 0);
        chk("reset_overflow", bus.TraceOverflow, 0);
        tick();
        chk("idle_hold_corereset", bus.CoreReset, 1);

        make_prog(5, 8'h11);   run_prog(0, -1, -1, 1'b0);   // halt after 5
        make_prog(10, 8'h00);  run_prog(0, -1, -1, 1'b0);   // overflow
        make_prog(MAX_CYCLES, 8'h00);     run_prog(0, -1, -1, 1'b0);  // timeout
        make_prog(MAX_CYCLES - 1, 8'h00); run_prog(0, -1, -1, 1'b0);  // halt on last budget cycle
        make_prog(11, 8'h00);  run_prog(2, -1, -1, 1'b0);   // push+pop while full
        make_prog(6, 8'h00);   run_prog(1, 3, -1, 1'b1);    // Start mid-run and mid-boot
        make_prog(20, 8'h00);  run_prog(1, -1, 5, 1'b0);    // reset mid-run

        for (int r = 0; r < 25; r++) begin
            make_prog($urandom_range(0, 15), 8'h00);
            run_prog($urandom_range(0, 2),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1,
                     ($urandom_range(0, 7) == 0) ? $urandom_range(0, 10) : -1,
                     1'($urandom_range(0, 1)));
        end

        chk("final_pending_reads", exp_q.size(), 0);
        chk("final_pending_end", end_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end
endmodule
`default_nettype wire
